// File: rtl/crypto_pkg.sv
// rtl/crypto_pkg.sv - shared cipher constants, FSM state type and round/key-schedule functions
// Imported by cripto and decipher_core so both sides of the cipher stay bit-consistent.
// The functions operate on CRYPTO_W-bit words; rotate amounts and round constants are arguments.
package crypto_pkg;

  localparam int                  CRYPTO_W      = 10;
  localparam int                  CRYPTO_ROUNDS = 4;
  localparam int                  CRYPTO_ROT    = 3;
  localparam logic [CRYPTO_W-1:0] CRYPTO_RC     = 10'h15B;

  typedef logic [CRYPTO_W-1:0] word_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXPAND,
    ST_DECRYPT,
    ST_DONE
  } state_t;

  function automatic word_t rotl(input word_t v, input int n);
    rotl = (v << n) | (v >> (CRYPTO_W - n));
  endfunction

  function automatic word_t rotr(input word_t v, input int n);
    rotr = (v >> n) | (v << (CRYPTO_W - n));
  endfunction

  // rk[i+1] = rotl(rk[i],1) ^ (i+1); idx carries the already-incremented index.
  function automatic word_t key_step_fwd(input word_t rk, input word_t idx);
    key_step_fwd = rotl(rk, 1) ^ idx;
  endfunction

  // rk[i-1] = rotr(rk[i] ^ i, 1); idx carries the current index i.
  function automatic word_t key_step_bwd(input word_t rk, input word_t idx);
    key_step_bwd = rotr(rk ^ idx, 1);
  endfunction

  function automatic word_t enc_round(input word_t x, input word_t rk, input int rot, input word_t rc);
    enc_round = rotl(x ^ rk, rot) + rc;
  endfunction

  function automatic word_t dec_round(input word_t y, input word_t rk, input int rot, input word_t rc);
    dec_round = rotr(y - rc, rot) ^ rk;
  endfunction

endpackage

// File: rtl/decipher_round.sv
// rtl/decipher_round.sv - combinational single decrypt round plus backward key step
// Ports:
//   y       in   ciphertext-side word for this round
//   rk      in   round key rk[i]
//   idx     in   round index i, zero-extended
//   x       out  plaintext-side word after undoing round i
//   rk_prev out  rk[i-1] (meaningless when i == 0)
module decipher_round import crypto_pkg::*; #(
  parameter int    ROT = CRYPTO_ROT,
  parameter word_t RC  = CRYPTO_RC
) (
  input  logic [CRYPTO_W-1:0] y,
  input  logic [CRYPTO_W-1:0] rk,
  input  logic [CRYPTO_W-1:0] idx,
  output logic [CRYPTO_W-1:0] x,
  output logic [CRYPTO_W-1:0] rk_prev
);

  assign x       = dec_round(y, rk, ROT, RC);
  assign rk_prev = key_step_bwd(rk, idx);

endmodule

// File: rtl/decipher_core.sv
// rtl/decipher_core.sv - iterative block decryptor, inverse of cripto
// Optional build macro: DECIPHER_KEY_CACHE_EN (caches rk[ROUNDS-1] of the last key to skip EXPAND).
// WIDTH must equal crypto_pkg::CRYPTO_W; the shared round functions are fixed to that width.
// Ports:
//   clk         in   clock
//   reset       in   synchronous, active-high reset
//   in_valid    in   request valid
//   in_ready    out  core idle, can accept a request
//   ciphertext  in   block to decrypt, sampled at accept
//   key         in   cipher key, sampled at accept
//   out_valid   out  plaintext valid
//   out_ready   in   consumer takes the result
//   plaintext   out  decrypted block (last completed result)
//   busy        out  high in EXPAND or DECRYPT
module decipher_core import crypto_pkg::*; #(
  parameter int               WIDTH  = CRYPTO_W,
  parameter int               ROUNDS = CRYPTO_ROUNDS,
  parameter int               ROT    = CRYPTO_ROT,
  parameter logic [WIDTH-1:0] RC     = CRYPTO_RC
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] ciphertext,
  input  logic [WIDTH-1:0] key,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] plaintext,
  output logic             busy
);

  localparam int             CNT_W    = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
  localparam logic [CNT_W-1:0] CNT_ONE  = 1;
  localparam logic [CNT_W-1:0] LAST_EXP = CNT_W'(ROUNDS - 2);
  localparam logic [CNT_W-1:0] LAST_RND = CNT_W'(ROUNDS - 1);

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] data;
  logic [WIDTH-1:0] rk;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [WIDTH-1:0] plaintext_q;
  logic [WIDTH-1:0] rk_fwd;
  logic [WIDTH-1:0] round_x;
  logic [WIDTH-1:0] round_rk_prev;
  logic             cache_hit;
  logic [WIDTH-1:0] cache_rk;

  assign cnt_inc = cnt + CNT_ONE;
  assign rk_fwd  = key_step_fwd(rk, {{(WIDTH-CNT_W){1'b0}}, cnt_inc});

  decipher_round #(
    .ROT (ROT),
    .RC  (RC)
  ) u_round (
    .y       (data),
    .rk      (rk),
    .idx     ({{(WIDTH-CNT_W){1'b0}}, cnt}),
    .x       (round_x),
    .rk_prev (round_rk_prev)
  );

`ifdef DECIPHER_KEY_CACHE_EN
  logic [WIDTH-1:0] last_key;
  logic [WIDTH-1:0] last_rk;
  logic             cache_valid;

  // last_key is captured on a missing accept and only becomes usable once
  // its EXPAND finishes, so an aborted expansion never leaves a bad entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_key    <= '0;
      last_rk     <= '0;
      cache_valid <= 1'b0;
    end else begin
      if (state == ST_IDLE && in_valid && !cache_hit) begin
        last_key    <= key;
        cache_valid <= 1'b0;
      end
      if (state == ST_EXPAND && cnt == LAST_EXP) begin
        last_rk     <= rk_fwd;
        cache_valid <= 1'b1;
      end
    end
  end

  assign cache_hit = cache_valid && (key == last_key);
  assign cache_rk  = last_rk;
`else
  assign cache_hit = 1'b0;
  assign cache_rk  = key;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (in_valid) begin
          next_state = (ROUNDS == 1 || cache_hit) ? ST_DECRYPT : ST_EXPAND;
        end
      end
      ST_EXPAND: begin
        if (cnt == LAST_EXP) begin
          next_state = ST_DECRYPT;
        end
      end
      ST_DECRYPT: begin
        if (cnt == '0) begin
          next_state = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          next_state = ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == ST_IDLE);
    out_valid = (state == ST_DONE);
    busy      = (state == ST_EXPAND) || (state == ST_DECRYPT);
  end

  // Rounds are undone from ROUNDS-1 down to 0 while the key walks backward,
  // so only the current round key is ever stored.
  always_ff @(posedge clk) begin
    if (reset) begin
      data        <= '0;
      rk          <= '0;
      cnt         <= '0;
      plaintext_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            data <= ciphertext;
            if (cache_hit) begin
              rk  <= cache_rk;
              cnt <= LAST_RND;
            end else begin
              rk  <= key;
              cnt <= '0;
            end
          end
        end
        ST_EXPAND: begin
          rk  <= rk_fwd;
          cnt <= cnt_inc;
        end
        ST_DECRYPT: begin
          data <= round_x;
          if (cnt != '0) begin
            rk  <= round_rk_prev;
            cnt <= cnt - CNT_ONE;
          end else begin
            plaintext_q <= round_x;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign plaintext = plaintext_q;

endmodule
